// File: rtl/rr_output_allocator_if.sv
// Request/grant bundle between the input-buffer/LBDR stages and one output-port allocator.
// slave = allocator side, master = input buffers / downstream credit source.
interface rr_output_allocator_if #(
  parameter int unsigned NPORTS = 5,
  parameter int unsigned CW     = 3
);
  logic [NPORTS-1:0]   req;
  logic [NPORTS-1:0]   valid;
  logic [3*NPORTS-1:0] flit_id;
  logic                credit_in;
  logic [NPORTS-1:0]   grant;
  logic [2:0]          xbar_sel;
  logic [NPORTS-1:0]   read_en;
  logic                valid_out;
  logic [CW-1:0]       credit_cnt;
  logic                credit_err;

  modport master (
    output req, valid, flit_id, credit_in,
    input  grant, xbar_sel, read_en, valid_out, credit_cnt, credit_err
  );

  modport slave (
    input  req, valid, flit_id, credit_in,
    output grant, xbar_sel, read_en, valid_out, credit_cnt, credit_err
  );
endinterface

// File: rtl/rr_output_allocator.sv
// Round-robin wormhole allocator for one router output port.
// Locks onto a HEADER winner until its TAIL is forwarded; pops only with downstream credit.
module rr_output_allocator #(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3
) (
  input logic                  clk,
  input logic                  rst,
  rr_output_allocator_if.slave bus
);
  localparam logic [2:0]    HEADER = 3'b001;
  localparam logic [2:0]    TAIL   = 3'b100;
  localparam logic [CW-1:0] CMAX   = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] is_tail;
  logic [NPORTS-1:0] read_en;
  logic [2:0]        xbar_sel;
  logic [2:0]        rr_ptr;
  logic [2:0]        winner;
  logic [2:0]        idx_sel;
  logic              found;
  logic              fwd;
  logic              tail_fwd;
  logic [CW-1:0]     credit_cnt;
  logic              credit_err;
  int unsigned       idx;

  always_comb begin
    eligible = '0;
    is_tail  = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      eligible[i] = bus.req[i] & bus.valid[i] & (bus.flit_id[3*i +: 3] == HEADER);
      is_tail[i]  = (bus.flit_id[3*i +: 3] == TAIL);
    end
  end

  // First eligible input scanning rr_ptr, rr_ptr+1, ... with wrap at NPORTS.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx     = 0;
    idx_sel = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      idx_sel = 3'(idx);
      if (!found && eligible[idx_sel]) begin
        found  = 1'b1;
        winner = idx_sel;
      end
    end
  end

  // grant is one-hot while LOCKED, so masking with valid isolates the winner's FIFO.
  always_comb begin
    read_en = '0;
    if (state == LOCKED && credit_cnt != '0) read_en = grant & bus.valid;
  end

  assign fwd      = |read_en;
  assign tail_fwd = |(read_en & is_tail);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      xbar_sel   <= '0;
      rr_ptr     <= '0;
      credit_cnt <= CMAX;
      credit_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= LOCKED;
            grant    <= NPORTS'(1) << winner;
            xbar_sel <= winner;
          end
        end
        LOCKED: begin
          if (tail_fwd) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (xbar_sel == 3'(NPORTS - 1)) ? '0 : xbar_sel + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (fwd && !bus.credit_in) begin
        credit_cnt <= credit_cnt - CW'(1);
      end else if (bus.credit_in && !fwd) begin
        if (credit_cnt == CMAX) credit_err <= 1'b1;
        else                    credit_cnt <= credit_cnt + CW'(1);
      end
    end
  end

  assign bus.grant      = grant;
  assign bus.xbar_sel   = xbar_sel;
  assign bus.read_en    = read_en;
  assign bus.valid_out  = fwd;
  assign bus.credit_cnt = credit_cnt;
  assign bus.credit_err = credit_err;
endmodule
